// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner: FSM states,
// the "no key" candidate encoding and the {row,col} -> hex key map.
package keypad_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        DEBOUNCE_PRESS,
        PRESSED,
        DEBOUNCE_RELEASE
    } state_t;

    // Scan candidate: bit 4 set means no key, or more than one key.
    localparam logic [4:0] KEY_NONE = 5'b1_0000;

    // Indexed by {row, col}; entry 15 is listed first.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Rows idle high, so the flops reset to all ones.
module sync2 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // NOTE: non-blocking assignments keep these as two distinct flop stages.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with scan-level debounce and a one-cycle KeyValid.
// Define KEYPAD_ACCUM_EN to add the 16-bit entered-digit accumulator Number.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  Row,
    output logic [3:0]  Col,
    output logic [3:0]  KeyCode,
    output logic        KeyValid,
`ifdef KEYPAD_ACCUM_EN
    output logic        KeyHeld,
    output logic [15:0] Number
`else
    output logic        KeyHeld
`endif
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]    row_s;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;
    state_t        state;
    logic [3:0]    stored;
    logic [CW-1:0] cnt;

    logic          last_dwell;
    logic          scan_end;
    logic [2:0]    col_cnt;
    logic [1:0]    col_row;
    logic [2:0]    hit_sum;
    logic [3:0]    code_now;
    logic [4:0]    cand;
    logic [CW-1:0] cnt_inc;
    logic          held_match;
    logic          accept;

    sync2 u_sync2 (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (Row),
        .q     (row_s)
    );

    // The scan result folds the current column's sample in, so the FSM acts on
    // the same edge that takes the Col[3] sample.
    always_comb begin
        last_dwell = (dwell == DW'(SCAN_DIV - 1));
        scan_end   = last_dwell && (col_idx == 2'd3);
        col_cnt    = '0;
        col_row    = '0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) begin
                col_cnt = col_cnt + 3'd1;
                col_row = 2'(r);
            end
        end
        hit_sum    = {1'b0, acc_cnt} + col_cnt;
        code_now   = (col_cnt == 3'd1) ? KEY_MAP[{col_row, col_idx}] : acc_code;
        cand       = (hit_sum == 3'd1) ? {1'b0, code_now} : KEY_NONE;
        cnt_inc    = cnt + CW'(1);
        held_match = (cand == {1'b0, KeyCode});
        accept     = scan_end && !cand[4] &&
                     (((state == RELEASED) && (DEBOUNCE_SCANS == 1)) ||
                      ((state == DEBOUNCE_PRESS) && (cand[3:0] == stored) &&
                       (cnt_inc == CW'(DEBOUNCE_SCANS))));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dwell    <= '0;
            col_idx  <= '0;
            Col      <= 4'b1110;
            acc_cnt  <= '0;
            acc_code <= '0;
        end else if (last_dwell) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            Col     <= {Col[2:0], Col[3]};
            if (col_idx == 2'd3) begin
                acc_cnt  <= '0;
                acc_code <= '0;
            end else begin
                acc_cnt  <= (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
                acc_code <= code_now;
            end
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= RELEASED;
            stored   <= '0;
            cnt      <= '0;
            KeyCode  <= '0;
            KeyValid <= 1'b0;
            KeyHeld  <= 1'b0;
        end else begin
            KeyValid <= 1'b0;
            if (accept) begin
                state    <= PRESSED;
                KeyCode  <= cand[3:0];
                KeyValid <= 1'b1;
                KeyHeld  <= 1'b1;
                cnt      <= '0;
            end else if (scan_end) begin
                case (state)
                    RELEASED: begin
                        if (!cand[4]) begin
                            state  <= DEBOUNCE_PRESS;
                            stored <= cand[3:0];
                            cnt    <= CW'(1);
                        end
                    end
                    DEBOUNCE_PRESS: begin
                        if (cand[4]) begin
                            state <= RELEASED;
                        end else if (cand[3:0] == stored) begin
                            cnt <= cnt_inc;
                        end else begin
                            stored <= cand[3:0];
                            cnt    <= CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!held_match) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state   <= RELEASED;
                                KeyHeld <= 1'b0;
                            end else begin
                                state <= DEBOUNCE_RELEASE;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    DEBOUNCE_RELEASE: begin
                        if (held_match) begin
                            state <= PRESSED;
                        end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            state   <= RELEASED;
                            KeyHeld <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= RELEASED;
                endcase
            end
        end
    end

`ifdef KEYPAD_ACCUM_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Number <= '0;
        end else if (accept) begin
            Number <= {Number[11:0], cand[3:0]};
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad and a KeyValid
// scoreboard; the Number checks are built when KEYPAD_ACCUM_EN is defined.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int SCAN           = 4 * SCAN_DIV;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Row;
    logic [3:0]  Col;
    logic [3:0]  KeyCode;
    logic        KeyValid;
    logic        KeyHeld;
`ifdef KEYPAD_ACCUM_EN
    logic [15:0] Number;
`endif

    logic [15:0] keys = '0;
    logic [3:0]  exp_q[$];
    int          checks      = 0;
    int          errors      = 0;
    int          valid_count = 0;
    int          v0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Row      (Row),
        .Col      (Col),
        .KeyCode  (KeyCode),
        .KeyValid (KeyValid),
`ifdef KEYPAD_ACCUM_EN
        .KeyHeld  (KeyHeld),
        .Number   (Number)
`else
        .KeyHeld  (KeyHeld)
`endif
    );

    always #5 Clk = ~Clk;

    // Keypad model: a pressed key {row,col} pulls its row low while its column is driven low.
    always_comb begin
        Row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            Row[r] = ~|(keys[r*4 +: 4] & ~Col);
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    // Wait for the start of a fresh scan (Col just rotated to 1110).
    task automatic align();
        int n = 0;
        while (Col !== 4'b0111 && n < 64) begin
            @(negedge Clk);
            n++;
        end
        while (Col !== 4'b1110 && n < 64) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 64) check("align_timeout", 16'(n), 16'd0);
        #1;
    endtask

    always @(negedge Clk) begin
        if (!Reset && KeyValid) begin
            valid_count++;
            if (exp_q.size() == 0) check("spurious_valid", 16'(KeyValid), 16'd0);
            else check("valid_code", 16'(KeyCode), 16'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then reset again in the middle of a column dwell.
        cycles(3);
        Reset = 1'b0;
        cycles(6);
        Reset = 1'b1;
        #1;
        check("rst_col", 16'(Col), 16'h000E);
        check("rst_valid", 16'(KeyValid), 16'h0);
        check("rst_held", 16'(KeyHeld), 16'h0);
        check("rst_code", 16'(KeyCode), 16'h0);
`ifdef KEYPAD_ACCUM_EN
        check("rst_number", Number, 16'h0000);
`endif
        cycles(2);
        Reset = 1'b0;
        cycles(3);
        check("col_dwell", 16'(Col), 16'h000E);
        cycles(1);
        check("col_step", 16'(Col), 16'h000D);

        // Key 5 held for 40 cycles, then released.
        align();
        v0 = valid_count;
        keys = 16'h0020;
        exp_q.push_back(4'h5);
        cycles(SCAN);
        check("k5_first_scan_held", 16'(KeyHeld), 16'h0);
        cycles(SCAN);
        check("k5_code", 16'(KeyCode), 16'h0005);
        check("k5_held", 16'(KeyHeld), 16'h1);
        cycles(8);
        keys = '0;
        cycles(8);
        check("k5_held_scan3", 16'(KeyHeld), 16'h1);
        cycles(SCAN);
        check("k5_release_debounce", 16'(KeyHeld), 16'h1);
        cycles(SCAN);
        check("k5_released", 16'(KeyHeld), 16'h0);
        check("k5_pulses", 16'(valid_count - v0), 16'd1);

        // Key A: present one scan, absent one, present two.
        v0 = valid_count;
        keys = 16'h0008;
        cycles(SCAN);
        keys = '0;
        cycles(SCAN);
        check("ka_glitch_held", 16'(KeyHeld), 16'h0);
        keys = 16'h0008;
        exp_q.push_back(4'hA);
        cycles(SCAN);
        check("ka_debounce_held", 16'(KeyHeld), 16'h0);
        cycles(SCAN);
        check("ka_code", 16'(KeyCode), 16'h000A);
        check("ka_pulses", 16'(valid_count - v0), 16'd1);
        keys = '0;
        cycles(2 * SCAN);
        check("ka_released", 16'(KeyHeld), 16'h0);

        // Keys 1 and 2 together are ambiguous and never reported.
        v0 = valid_count;
        keys = 16'h0003;
        cycles(5 * SCAN);
        check("multi_pulses", 16'(valid_count - v0), 16'd0);
        check("multi_held", 16'(KeyHeld), 16'h0);
        check("multi_code", 16'(KeyCode), 16'h000A);
        keys = '0;
        cycles(SCAN);

        // Key D bounce during release, then a direct change to key 8.
        v0 = valid_count;
        keys = 16'h8000;
        exp_q.push_back(4'hD);
        cycles(2 * SCAN);
        check("kd_code", 16'(KeyCode), 16'h000D);
        keys = '0;
        cycles(SCAN);
        check("kd_gap_held", 16'(KeyHeld), 16'h1);
        keys = 16'h8000;
        cycles(2 * SCAN);
        check("kd_repress_held", 16'(KeyHeld), 16'h1);
        check("kd_repress_pulses", 16'(valid_count - v0), 16'd1);
        keys = 16'h0200;
        exp_q.push_back(4'h8);
        cycles(SCAN);
        check("k8_rel1_held", 16'(KeyHeld), 16'h1);
        cycles(SCAN);
        check("k8_rel2_held", 16'(KeyHeld), 16'h0);
        check("k8_rel2_code", 16'(KeyCode), 16'h000D);
        cycles(SCAN);
        check("k8_press1_pulses", 16'(valid_count - v0), 16'd1);
        cycles(SCAN);
        check("k8_code", 16'(KeyCode), 16'h0008);
        check("k8_held", 16'(KeyHeld), 16'h1);
        check("k8_pulses", 16'(valid_count - v0), 16'd2);
        keys = '0;
        cycles(2 * SCAN);
        check("k8_released", 16'(KeyHeld), 16'h0);

        // Reset in the middle of a press debounce restarts the debounce.
        v0 = valid_count;
        keys = 16'h0040;
        cycles(SCAN);
        cycles(5);
        Reset = 1'b1;
        #1;
        check("rst_mid_held", 16'(KeyHeld), 16'h0);
        check("rst_mid_col", 16'(Col), 16'h000E);
        cycles(2);
        Reset = 1'b0;
        cycles(SCAN);
        check("rst_mid_no_pulse", 16'(valid_count - v0), 16'd0);
        exp_q.push_back(4'h6);
        cycles(SCAN);
        check("k6_code", 16'(KeyCode), 16'h0006);
        check("k6_pulses", 16'(valid_count - v0), 16'd1);
`ifdef KEYPAD_ACCUM_EN
        check("k6_number", Number, 16'h0006);
`endif
        keys = '0;
        cycles(2 * SCAN);

`ifdef KEYPAD_ACCUM_EN
        // Enter 1, 2, 3, A then 0 into the accumulator.
        begin
            logic [15:0] key_bits [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h1000};
            logic [3:0]  key_vals [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h0};
            for (int i = 0; i < 5; i++) begin
                keys = key_bits[i];
                exp_q.push_back(key_vals[i]);
                cycles(2 * SCAN);
                keys = '0;
                cycles(2 * SCAN);
                if (i == 3) check("number_123a", Number, 16'h123A);
            end
            check("number_23a0", Number, 16'h23A0);
        end
`endif

        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
